johnson_phase_monitor: RTL and testbench

JOHNSON_PHASE_MONITOR -- requirements
Module: johnson_phase_monitor

---
 rtl/johnson_pkg.sv | 23 ++
 rtl/johnson_decode.sv | 22 ++
 rtl/johnson_phase_monitor.sv | 119 +++++++++++
 tb/tb_johnson_phase_monitor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson phase monitor: widths, the legal code
// table indexed by phase, the terminal code and the monitor FSM encoding.
package johnson_pkg;

    localparam int JOHNSON_W = 4;
    localparam int PHASE_W   = 3;
    localparam int N_PHASES  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Entry i is the counter state that represents phase i.
    localparam logic [JOHNSON_W-1:0] CODE_TABLE [N_PHASES] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0111,
        4'b1111, 4'b1110, 4'b1100, 4'b1000
    };

    localparam logic [JOHNSON_W-1:0] TERM_CODE = 4'b1000;

endpackage

// File: rtl/johnson_decode.sv
// Combinational decode of a 4-bit Johnson code into its phase index.
// Codes outside the table report o_legal=0 and decode to phase 0.
module johnson_decode
    import johnson_pkg::*;
(
    input  logic [JOHNSON_W-1:0] i_q,
    output logic [PHASE_W-1:0]   o_phase,
    output logic                 o_legal
);

    always_comb begin
        o_phase = '0;
        o_legal = 1'b0;
        for (int i = 0; i < N_PHASES; i++) begin
            if (i_q == CODE_TABLE[i]) begin
                o_phase = PHASE_W'(i);
                o_legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Watches an upstream 4-bit Johnson counter, reports its phase, counts
// completed revolutions and latches a sticky fault on any inconsistency.
module johnson_phase_monitor
    import johnson_pkg::*;
#(
    parameter int REV_W = 8
) (
    input  logic                 clk,
    input  logic                 R,
    input  logic                 ce,
    input  logic [JOHNSON_W-1:0] Q,
    input  logic                 CEO,
    input  logic                 clr,
    output logic [PHASE_W-1:0]   phase,
    output logic                 phase_vld,
    output logic [REV_W-1:0]     rev_cnt,
    output logic                 rev_wrap,
    output logic                 err,
    output logic [1:0]           o_dbg_state
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [JOHNSON_W-1:0]   r_q_d;
    logic                   r_ce_d;
    logic [PHASE_W-1:0]     r_phase;
    logic                   r_phase_vld;
    logic [REV_W-1:0]       r_rev_cnt;
    logic                   r_rev_wrap;
    logic                   r_err;

    logic [PHASE_W-1:0]     w_cur_phase;
    logic                   w_cur_legal;
    logic [PHASE_W-1:0]     w_prev_phase;
    logic                   w_prev_legal;
    logic [PHASE_W-1:0]     w_exp_phase;
    logic                   w_term;
    logic                   w_fault;
    logic                   w_inc;

    johnson_decode u_dec_cur (
        .i_q     (Q),
        .o_phase (w_cur_phase),
        .o_legal (w_cur_legal)
    );

    johnson_decode u_dec_prev (
        .i_q     (r_q_d),
        .o_phase (w_prev_phase),
        .o_legal (w_prev_legal)
    );

    // The counter only advances on edges where ce was high, so the phase seen
    // now must be last cycle's phase plus last cycle's ce (mod 8).
    assign w_exp_phase = w_prev_phase + {{(PHASE_W-1){1'b0}}, r_ce_d};
    assign w_term      = ce && (Q == TERM_CODE);

    always_comb begin
        w_next_state = r_state;
        w_fault      = 1'b0;
        w_inc        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_state = w_cur_legal ? ST_TRACK : ST_FAULT;
            end
            ST_TRACK: begin
                w_fault = !w_cur_legal || !w_prev_legal ||
                          (w_cur_phase != w_exp_phase) || (CEO != w_term);
                if (w_fault) begin
                    w_next_state = ST_FAULT;
                end else begin
                    w_inc = ce && CEO;
                end
            end
            ST_FAULT: begin
                w_next_state = ST_FAULT;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        // A resync request overrides whatever was detected on this edge.
        if (clr) begin
            w_next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!R) begin
            r_state     <= ST_IDLE;
            r_q_d       <= '0;
            r_ce_d      <= 1'b0;
            r_phase     <= '0;
            r_phase_vld <= 1'b0;
            r_rev_cnt   <= '0;
            r_rev_wrap  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_q_d       <= Q;
            r_ce_d      <= ce;
            r_phase     <= w_cur_phase;
            r_phase_vld <= (w_next_state == ST_TRACK);
            r_err       <= (w_next_state == ST_FAULT);
            r_rev_wrap  <= w_inc && (&r_rev_cnt);
            if (w_inc) begin
                r_rev_cnt <= r_rev_cnt + 1'b1;
            end
        end
    end

    assign phase       = r_phase;
    assign phase_vld   = r_phase_vld;
    assign rev_cnt     = r_rev_cnt;
    assign rev_wrap    = r_rev_wrap;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Randomized and directed bench for johnson_phase_monitor, checking two
// instances (REV_W=8 and REV_W=2) against a phase-arithmetic reference model.
module tb_johnson_phase_monitor;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       R   = 1'b0;
    logic       ce  = 1'b0;
    logic       clr = 1'b0;
    logic       CEO = 1'b0;
    logic [3:0] Q   = 4'b0000;

    logic [2:0] phase_a, phase_b;
    logic       vld_a, vld_b, wrap_a, wrap_b, err_a, err_b;
    logic [7:0] rev_a;
    logic [1:0] rev_b;
    logic [1:0] dbg_a, dbg_b;

    johnson_phase_monitor #(.REV_W(8)) dut_a (
        .clk(clk), .R(R), .ce(ce), .Q(Q), .CEO(CEO), .clr(clr),
        .phase(phase_a), .phase_vld(vld_a), .rev_cnt(rev_a),
        .rev_wrap(wrap_a), .err(err_a), .o_dbg_state(dbg_a)
    );

    johnson_phase_monitor #(.REV_W(2)) dut_b (
        .clk(clk), .R(R), .ce(ce), .Q(Q), .CEO(CEO), .clr(clr),
        .phase(phase_b), .phase_vld(vld_b), .rev_cnt(rev_b),
        .rev_wrap(wrap_b), .err(err_b), .o_dbg_state(dbg_b)
    );

    // ---------------- reference model ----------------
    logic [3:0] code [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                             4'b1111, 4'b1110, 4'b1100, 4'b1000};

    int  n_vec  = 0;
    int  n_miss = 0;
    int  pos    = 0;          // upstream counter phase driven by the bench
    bit  m_tracking = 0;
    bit  m_faulted  = 0;
    int  m_prev_idx = 0;
    bit  m_prev_ce  = 0;
    int  m_revs     = 0;      // total revolutions since reset (unbounded)
    bit  m_wrap8    = 0;
    bit  m_wrap2    = 0;
    int  m_phase    = 0;

    // {rev8, rev2, wrap8, wrap2, err, vld, phase}
    logic [16:0] exp_q [$];

    function automatic int idx_of(input logic [3:0] q);
        for (int i = 0; i < 8; i++)
            if (code[i] == q) return i;
        return -1;
    endfunction

    function automatic void model_edge(input bit r, input bit c, input bit e,
                                       input logic [3:0] q, input bit co);
        int  idx;
        bit  bad;
        bit  inc;
        logic [7:0] r8;
        logic [1:0] r2;
        idx = idx_of(q);
        inc = 0;
        if (!r) begin
            m_tracking = 0; m_faulted = 0; m_prev_idx = 0; m_prev_ce = 0;
            m_revs = 0; m_phase = 0;
        end else begin
            if (!m_tracking && !m_faulted) begin
                m_tracking = (idx >= 0);
                m_faulted  = (idx < 0);
            end else if (m_tracking) begin
                bad = (idx < 0) || (idx != (m_prev_idx + int'(m_prev_ce)) % 8) ||
                      (co != (e && q == 4'b1000));
                if (bad) begin
                    m_tracking = 0;
                    m_faulted  = 1;
                end else begin
                    inc = e && co;
                end
            end
            if (c) begin
                m_tracking = 0;
                m_faulted  = 0;
            end
            if (inc) m_revs++;
            m_phase    = (idx < 0) ? 0 : idx;
            m_prev_idx = m_phase;
            m_prev_ce  = e;
        end
        m_wrap8 = inc && (m_revs % 256 == 0);
        m_wrap2 = inc && (m_revs % 4 == 0);
        r8 = 8'(m_revs % 256);
        r2 = 2'(m_revs % 4);
        exp_q.push_back({r8, r2, m_wrap8, m_wrap2, m_faulted, m_tracking, 3'(m_phase)});
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare();
        logic [16:0] e;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check("phase_a",  32'(phase_a), 32'(e[2:0]));
        check("vld_a",    32'(vld_a),   32'(e[3]));
        check("err_a",    32'(err_a),   32'(e[4]));
        check("wrap_b",   32'(wrap_b),  32'(e[5]));
        check("wrap_a",   32'(wrap_a),  32'(e[6]));
        check("rev_b",    32'(rev_b),   32'(e[8:7]));
        check("rev_a",    32'(rev_a),   32'(e[16:9]));
        check("phase_b",  32'(phase_b), 32'(e[2:0]));
        check("err_b",    32'(err_b),   32'(e[4]));
    endtask

    // ---------------- drivers ----------------
    task automatic step(input bit r, input bit c, input bit e,
                        input logic [3:0] q, input bit co);
        @(negedge clk);
        R = r; clr = c; ce = e; Q = q; CEO = co;
        @(posedge clk);
        model_edge(r, c, e, q, co);
        #1;
        compare();
    endtask

    // One cycle of a well-behaved upstream counter.
    task automatic cnt(input bit e, input bit c);
        step(1'b1, c, e, code[pos], e && (pos == 7));
        if (e) pos = (pos + 1) % 8;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        pos = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();
        check("reset_phase", 32'(phase_a), 32'd0);
        check("reset_rev",   32'(rev_a),   32'd0);

        // Clean run: two revolutions in 20 cycles.
        repeat (20) cnt(1'b1, 1'b0);
        check("rev_after_20", 32'(rev_a), 32'd2);
        check("vld_after_20", 32'(vld_a), 32'd1);

        // Illegal code glitch, then clr and recovery.
        step(1'b1, 1'b0, 1'b1, 4'b0101, 1'b0);
        pos = (pos + 1) % 8;
        check("glitch_err", 32'(err_a), 32'd1);
        repeat (3) cnt(1'b1, 1'b0);
        cnt(1'b1, 1'b1);
        check("clr_err", 32'(err_a), 32'd0);
        repeat (4) cnt(1'b1, 1'b0);

        // Missing carry-out at the terminal code.
        while (pos != 7) cnt(1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, code[7], 1'b0);
        pos = 0;
        check("ceo_missing_err", 32'(err_a), 32'd1);
        cnt(1'b1, 1'b0);
        cnt(1'b1, 1'b1);
        repeat (3) cnt(1'b1, 1'b0);
        // Spurious carry-out away from the terminal code.
        while (pos != 2) cnt(1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, code[2], 1'b1);
        pos = 3;
        check("ceo_spurious_err", 32'(err_a), 32'd1);
        cnt(1'b1, 1'b1);

        // Irregular ce with a matching counter must not fault.
        repeat (200) cnt(1'($urandom_range(0, 1)), 1'b0);
        check("irregular_ce_err", 32'(err_a), 32'd0);

        // Phase skip 0001 -> 0111.
        while (pos != 1) cnt(1'b1, 1'b0);
        cnt(1'b1, 1'b0);
        pos = 3;
        cnt(1'b1, 1'b0);
        check("skip_err", 32'(err_a), 32'd1);

        // Reset together with clr while faulted.
        step(1'b0, 1'b1, 1'b1, code[pos], 1'b0);
        check("rst_clr_err", 32'(err_a), 32'd0);
        check("rst_clr_rev", 32'(rev_a), 32'd0);
        repeat (12) cnt(1'b1, 1'b0);

        // Phase skip coinciding with clr: clr wins.
        pos = (pos + 1) % 8;
        cnt(1'b1, 1'b1);
        check("skip_with_clr_err", 32'(err_a), 32'd0);
        repeat (4) cnt(1'b1, 1'b0);

        // Random soak: occasional resets, clears and corrupted codes.
        repeat (400) begin
            bit r, c, e;
            r = ($urandom_range(0, 49) != 0);
            c = ($urandom_range(0, 19) == 0);
            e = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) begin
                step(r, c, e, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                if (e) pos = (pos + 1) % 8;
            end else begin
                cnt(e, c);
            end
        end

        // Long clean run to wrap the 8-bit counter.
        do_reset();
        repeat (2100) cnt(1'b1, 1'b0);
        check("long_run_rev", 32'(rev_a), 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
